// File: rtl/clkwiz_controller_if.sv
// clkwiz_controller_if: signals exchanged between the clock controller and the Clocking Wizard (MMCM)
`timescale 1ns/1ps
interface clkwiz_controller_if;
    logic clkwiz_clkin;
    logic clkwiz_reset;
    logic clkwiz_clkout0;
    logic clkwiz_clkout1;
    logic clkwiz_locked;
    modport master (
        output clkwiz_clkin, clkwiz_reset,
        input  clkwiz_clkout0, clkwiz_clkout1, clkwiz_locked
    );
    modport slave (
        input  clkwiz_clkin, clkwiz_reset,
        output clkwiz_clkout0, clkwiz_clkout1, clkwiz_locked
    );
endinterface

// File: rtl/clkwiz_controller.sv
// clkwiz_controller: MMCM input select, reset sequencing, lock report and clk frequency meter
`timescale 1ns/1ps
module clkwiz_controller #(
    parameter int FMEAS_GATE   = 100000,
    parameter int FMEAS_SETTLE = 16,
    parameter int RST_SYNC     = 4
) (
    input  logic                 pl_clk0,
    input  logic                 pl_reset_n,
    input  logic                 clk_reset,
    input  logic                 sys_reset,
    input  logic                 clk0,
    input  logic                 clk1,
    input  logic                 clkin_src_sel,
    clkwiz_controller_if.master  mmcm,
    output logic                 clk,
    output logic                 reset,
    output logic                 clk_locked,
    input  logic                 fmeas_enable,
    output logic [23:0]          fmeas_count
);
    localparam int cnt_w = $clog2((FMEAS_GATE > FMEAS_SETTLE ? FMEAS_GATE : FMEAS_SETTLE) + 1);
    typedef enum logic [1:0] {IDLE, GATE, SETTLE} fm_state_t;
    fm_state_t state_q, state_d;
    logic [cnt_w-1:0] tick_q, tick_d;
    logic gate_q, gate_d;
    logic [23:0] fmeas_count_d;
    logic sel_q, sys_reset_q, lock_meta, lock_sync, rst_cause;
    logic [RST_SYNC-1:0] rst_chain;
    logic [2:0] gate_sync;
    logic [23:0] clk_count;
    logic unused_clkout1;
    assign unused_clkout1 = mmcm.clkwiz_clkout1;
    assign mmcm.clkwiz_clkin = sel_q ? clk1 : clk0;
    assign clk = mmcm.clkwiz_clkout0;
    always_ff @(posedge pl_clk0 or posedge pl_reset_n)
        if (pl_reset_n) begin
            mmcm.clkwiz_reset <= 1'b1;
            sys_reset_q       <= 1'b1;
            sel_q             <= 1'b0;
            {lock_sync, lock_meta} <= 2'b00;
        end else begin
            mmcm.clkwiz_reset <= clk_reset;
            sys_reset_q       <= sys_reset;
            sel_q             <= mmcm.clkwiz_reset ? clkin_src_sel : sel_q;
            {lock_sync, lock_meta} <= mmcm.clkwiz_reset ? 2'b00 : {lock_meta, mmcm.clkwiz_locked};
        end
    assign clk_locked = lock_sync & ~mmcm.clkwiz_reset;
    // any cause presets the chain at once; release walks through RST_SYNC clk edges
    assign rst_cause = pl_reset_n | mmcm.clkwiz_reset | sys_reset_q | ~mmcm.clkwiz_locked;
    always_ff @(posedge clk or posedge rst_cause)
        if (rst_cause) rst_chain <= '1;
        else rst_chain <= {rst_chain[RST_SYNC-2:0], 1'b0};
    assign reset = rst_chain[RST_SYNC-1];
    always_ff @(posedge pl_clk0 or posedge pl_reset_n)
        if (pl_reset_n) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            gate_q      <= 1'b0;
            fmeas_count <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            gate_q      <= gate_d;
            fmeas_count <= fmeas_count_d;
        end
    always_comb begin
        state_d       = state_q;
        tick_d        = tick_q + cnt_w'(1);
        gate_d        = gate_q;
        fmeas_count_d = fmeas_count;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (fmeas_enable) begin
                    gate_d  = 1'b1;
                    state_d = GATE;
                end
            end
            GATE:
                if (tick_q == cnt_w'(FMEAS_GATE - 1)) begin
                    tick_d  = '0;
                    gate_d  = 1'b0;
                    state_d = SETTLE;
                end
            SETTLE:
                if (tick_q == cnt_w'(FMEAS_SETTLE - 1)) begin
                    fmeas_count_d = clk_count;
                    state_d       = IDLE;
                end
            default: state_d = IDLE;
        endcase
    end
    // gate_sync: [0] meta, [1] synced gate, [2] previous synced gate for edge detect
    always_ff @(posedge clk or posedge pl_reset_n)
        if (pl_reset_n) begin
            gate_sync <= '0;
            clk_count <= '0;
        end else begin
            gate_sync <= {gate_sync[1:0], gate_q};
            clk_count <= (gate_sync[1] && !gate_sync[2]) ? 24'd1 :
                         (gate_sync[1] && clk_count != 24'hFFFFFF) ? clk_count + 24'd1 : clk_count;
        end
endmodule

// File: tb/tb_clkwiz_controller.sv
// tb_clkwiz_controller: directed vectors and sequences for the clock/reset front end and frequency meter
`timescale 1ns/1ps
module tb_clkwiz_controller;
    localparam int GATE = 1000;
    localparam int SETTLE = 16;
    typedef struct {
        logic sel;
        int   mode;
        int   exp_count;
    } vec_t;
    logic pl_clk0 = 0, pl_reset_n = 1, clk_reset = 1, sys_reset = 1, clkin_src_sel = 0;
    logic fmeas_enable = 0, s_enable = 0, clk1 = 0, clk50 = 0, locked = 0;
    logic clk0, clk, reset, clk_locked, unused_s_clk, s_reset, s_locked;
    logic [23:0] fmeas_count, s_count;
    int mode = 0;
    int checks = 0, errors = 0;
    vec_t vecs[5];
    assign clk0 = pl_clk0;
    always #5 pl_clk0 = ~pl_clk0;
    always #5.208 clk1 = ~clk1;
    initial begin
        #3;
        forever #10 clk50 = ~clk50;
    end
    // MMCM model: mode 0 passes clkin through 1:1, mode 1 is a free 50 MHz clock, mode 2 is stopped
    clkwiz_controller_if mmcm ();
    assign mmcm.clkwiz_clkout0 = mmcm.clkwiz_reset ? 1'b0 : mode == 0 ? mmcm.clkwiz_clkin : mode == 1 ? clk50 : 1'b0;
    assign mmcm.clkwiz_clkout1 = 1'b0;
    assign mmcm.clkwiz_locked = locked;
    clkwiz_controller #(.FMEAS_GATE(GATE), .FMEAS_SETTLE(SETTLE), .RST_SYNC(4)) dut (
        .pl_clk0(pl_clk0), .pl_reset_n(pl_reset_n), .clk_reset(clk_reset), .sys_reset(sys_reset),
        .clk0(clk0), .clk1(clk1), .clkin_src_sel(clkin_src_sel), .mmcm(mmcm),
        .clk(clk), .reset(reset), .clk_locked(clk_locked),
        .fmeas_enable(fmeas_enable), .fmeas_count(fmeas_count)
    );
    clkwiz_controller_if mmcm_s ();
    assign mmcm_s.clkwiz_clkout0 = mmcm_s.clkwiz_reset ? 1'b0 : mmcm_s.clkwiz_clkin;
    assign mmcm_s.clkwiz_clkout1 = 1'b0;
    assign mmcm_s.clkwiz_locked = 1'b1;
    clkwiz_controller #(.FMEAS_GATE(16), .FMEAS_SETTLE(16), .RST_SYNC(4)) dut_s (
        .pl_clk0(pl_clk0), .pl_reset_n(pl_reset_n), .clk_reset(1'b0), .sys_reset(1'b0),
        .clk0(clk0), .clk1(clk1), .clkin_src_sel(1'b0), .mmcm(mmcm_s),
        .clk(unused_s_clk), .reset(s_reset), .clk_locked(s_locked),
        .fmeas_enable(s_enable), .fmeas_count(s_count)
    );
    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(posedge pl_clk0);
        #1;
    endtask
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
    initial begin
        vecs[0] = '{sel: 1'b0, mode: 0, exp_count: 1000};
        vecs[1] = '{sel: 1'b1, mode: 0, exp_count: 960};
        vecs[2] = '{sel: 1'b0, mode: 1, exp_count: 500};
        vecs[3] = '{sel: 1'b1, mode: 0, exp_count: 960};
        vecs[4] = '{sel: 1'b0, mode: 0, exp_count: 1000};
        #100;
        check("rst_clkwiz_reset", mmcm.clkwiz_reset, 1, 0);
        check("rst_reset", reset, 1, 0);
        check("rst_clk_locked", clk_locked, 0, 0);
        check("rst_fmeas_count", fmeas_count, 0, 0);
        pl_reset_n = 0;
        cyc(3);
        check("clkwiz_reset_held", mmcm.clkwiz_reset, 1, 0);
        s_enable = 1;
        cyc(1);
        s_enable = 0;
        cyc(99);
        clk_reset = 0;
        check("clkwiz_reset_before_edge", mmcm.clkwiz_reset, 1, 0);
        cyc(1);
        check("clkwiz_reset_after_edge", mmcm.clkwiz_reset, 0, 0);
        check("sat_count", s_count, 16, 2);
        check("sat_locked", s_locked, 1, 0);
        check("sat_reset", s_reset, 0, 0);
        cyc(5);
        locked = 1;
        cyc(3);
        check("lock_sync", clk_locked, 1, 0);
        check("reset_held_by_sys", reset, 1, 0);
        cyc(100);
        mode = 1;
        cyc(10);
        sys_reset = 0;
        @(posedge pl_clk0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_after_3_edges", reset, 1, 0);
        @(posedge clk);
        #1;
        check("reset_after_4_edges", reset, 0, 0);
        locked = 0;
        #1;
        check("reset_on_lock_loss", reset, 1, 0);
        cyc(3);
        check("clk_locked_on_loss", clk_locked, 0, 0);
        locked = 1;
        mode = 0;
        cyc(10);
        for (int i = 0; i < 5; i++) begin
            clk_reset = 1;
            locked = 0;
            clkin_src_sel = vecs[i].sel;
            mode = vecs[i].mode;
            cyc(3);
            check($sformatf("v%0d_locked_in_reset", i), clk_locked, 0, 0);
            clk_reset = 0;
            cyc(2);
            locked = 1;
            cyc(4);
            check($sformatf("v%0d_locked", i), clk_locked, 1, 0);
            clkin_src_sel = ~vecs[i].sel;
            cyc(2);
            fmeas_enable = 1;
            cyc(1);
            fmeas_enable = 0;
            cyc(GATE + SETTLE + 20);
            check($sformatf("v%0d_count", i), fmeas_count, vecs[i].exp_count, 2);
        end
        mode = 2;
        cyc(5);
        fmeas_enable = 1;
        cyc(1);
        fmeas_enable = 0;
        cyc(GATE + SETTLE + 20);
        check("stopped_clk_stale", fmeas_count, 1000, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
